// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter in front of a sync FIFO write port; holds the grant for a
// whole packet (or a stalled beat) and tags each beat with the source index.
module fifo_wr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_WIDTH = 32,
  localparam int ID_WIDTH = $clog2(NUM_REQ)
) (
  input  logic                            clk_i,
  input  logic                            rstn_i,
  input  logic [NUM_REQ-1:0]              req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data_i,
  input  logic [NUM_REQ-1:0]              req_last_i,
  output logic [NUM_REQ-1:0]              req_ready_o,
  output logic                            out_valid_o,
  output logic [DATA_WIDTH-1:0]           out_data_o,
  output logic                            out_last_o,
  output logic [ID_WIDTH-1:0]             out_id_o,
  input  logic                            out_ready_i
);

  // Handshake: a beat moves when out_valid_o && out_ready_i; the granted
  // producer sees req_ready_o[grant] = out_ready_i combinationally.

  logic [ID_WIDTH-1:0] rr_ptr;
  logic                lock;
  logic [ID_WIDTH-1:0] lock_id;

  logic [ID_WIDTH-1:0] scan_id;
  logic                found;
  logic [ID_WIDTH-1:0] grant;
  logic                has_grant;
  logic                sel_valid;
  logic                sel_last;
  logic                hs;

  // Modular add that keeps the pointer inside 0..NUM_REQ-1 for any NUM_REQ.
  function automatic logic [ID_WIDTH-1:0] wrap_add(input logic [ID_WIDTH-1:0] base,
                                                    input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return ID_WIDTH'(s);
  endfunction

  // Reverse scan so the candidate nearest rr_ptr is the one left standing.
  always_comb begin
    scan_id = rr_ptr;
    found   = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid_i[wrap_add(rr_ptr, i)]) begin
        scan_id = wrap_add(rr_ptr, i);
        found   = 1'b1;
      end
    end
  end

  assign grant     = lock ? lock_id : scan_id;
  assign has_grant = lock | found;
  assign sel_valid = req_valid_i[grant];
  assign sel_last  = req_last_i[grant];
  assign hs        = sel_valid & out_ready_i;

  always_comb begin
    out_valid_o = rstn_i & sel_valid;
    out_data_o  = '0;
    out_last_o  = 1'b0;
    out_id_o    = rstn_i ? grant : '0;
    req_ready_o = '0;
    if (rstn_i && sel_valid) begin
      out_data_o = req_data_i[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
      out_last_o = sel_last;
    end
    if (rstn_i && has_grant) req_ready_o[grant] = out_ready_i;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rr_ptr  <= '0;
      lock    <= 1'b0;
      lock_id <= '0;
    end else if (!lock) begin
      if (sel_valid) begin
        if (hs && sel_last) begin
          rr_ptr <= wrap_add(grant, 1);
        end else begin
          // Freeze the grant so a presented or partial packet is never preempted.
          lock    <= 1'b1;
          lock_id <= grant;
        end
      end
    end else if (hs && sel_last) begin
      lock   <= 1'b0;
      rr_ptr <= wrap_add(lock_id, 1);
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: a 4-requester/32-bit instance and a
// 3-requester/8-bit instance for the non-power-of-two wrap.
module tb_fifo_wr_arbiter;

  logic         clk = 1'b0;
  logic         rstn;
  logic [3:0]   rv, rl, rr;
  logic [127:0] rd;
  logic         ov, ol, ordy;
  logic [31:0]  od;
  logic [1:0]   oid;

  logic [2:0]   rv3, rl3, rr3;
  logic [23:0]  rd3;
  logic         ov3, ol3, ordy3;
  logic [7:0]   od3;
  logic [1:0]   oid3;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(32)) dut (
    .clk_i(clk), .rstn_i(rstn), .req_valid_i(rv), .req_data_i(rd),
    .req_last_i(rl), .req_ready_o(rr), .out_valid_o(ov), .out_data_o(od),
    .out_last_o(ol), .out_id_o(oid), .out_ready_i(ordy)
  );

  fifo_wr_arbiter #(.NUM_REQ(3), .DATA_WIDTH(8)) dut3 (
    .clk_i(clk), .rstn_i(rstn), .req_valid_i(rv3), .req_data_i(rd3),
    .req_last_i(rl3), .req_ready_o(rr3), .out_valid_o(ov3), .out_data_o(od3),
    .out_last_o(ol3), .out_id_o(oid3), .out_ready_i(ordy3)
  );

  function automatic logic [31:0] dat(input int k);
    return 32'hD000_0000 + 32'(k) * 32'h0000_0101;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic at_sample;
    @(negedge clk);
  endtask

  task automatic at_drive;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] one;
    logic [31:0] e;
    one = 4'b0001;

    // Reset with every requester valid: outputs must stay gated low.
    rstn = 1'b0; rv = 4'hF; rl = 4'hF; ordy = 1'b1;
    for (int k = 0; k < 4; k++) rd[k*32 +: 32] = dat(k);
    rv3 = '0; rl3 = 3'b111; ordy3 = 1'b1; rd3 = {8'h33, 8'h22, 8'h11};
    at_sample;
    check("rst_valid", ov, 0);
    check("rst_ready", rr, 0);
    check("rst_id", oid, 0);
    check("rst_data", od, 0);
    check("rst_last", ol, 0);
    at_drive;
    rstn = 1'b1; rv = 4'h0;
    at_sample;
    check("idle_valid", ov, 0);
    check("idle_ready", rr, 0);
    check("idle_ptr", dut.rr_ptr, 0);
    check("idle_id", oid, 0);

    // All valid, single-beat packets: grant rotates 0..3 with no bubble.
    at_drive;
    rv = 4'hF; rl = 4'hF;
    for (int i = 0; i < 8; i++) exp_q.push_back(32'(i % 4));
    for (int i = 0; i < 8; i++) begin
      at_sample;
      e = exp_q.pop_front();
      check("rot_id", oid, e);
      check("rot_ready", rr, one << e[1:0]);
      check("rot_data", od, dat(int'(e)));
      check("rot_valid", ov, 1);
      at_drive;
    end
    rv = 4'h0;
    at_sample;
    check("rot_ptr", dut.rr_ptr, 0);

    // Move pointer to 1, then req1 sends 3 beats while req0/req2 wait.
    at_drive;
    rv = 4'b0001;
    at_sample;
    check("pre_id", oid, 0);
    for (int b = 0; b < 3; b++) begin
      at_drive;
      rv = 4'b0111;
      rl = (b == 2) ? 4'b1111 : 4'b1101;
      at_sample;
      check("pkt_id", oid, 1);
      check("pkt_last", ol, (b == 2) ? 1 : 0);
      check("pkt_ready", rr, 4'b0010);
    end
    at_drive;
    rv = 4'b0101; rl = 4'hF;
    at_sample;
    check("post_id2", oid, 2);
    at_drive;
    at_sample;
    check("post_id0", oid, 0);

    // FIFO full with req2 presented; req0 arrives during the stall.
    at_drive;
    rv = 4'b0100; ordy = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (c >= 1) rv = 4'b0101;
      at_sample;
      check("stall_id", oid, 2);
      check("stall_data", od, dat(2));
      check("stall_ready", rr, 0);
      check("stall_valid", ov, 1);
      at_drive;
    end
    ordy = 1'b1;
    at_sample;
    check("resume_id", oid, 2);
    check("resume_ready", rr, 4'b0100);
    at_drive;
    rv = 4'b0001;
    at_sample;
    check("after_id", oid, 0);
    at_drive;
    rv = 4'b0000;

    // Three requesters: pointer wraps 2 -> 0 and stays below 3.
    rv3 = 3'b100;
    at_sample;
    check("n3_id", oid3, 2);
    check("n3_data", od3, 8'h33);
    at_drive;
    rv3 = 3'b000;
    at_sample;
    check("n3_wrap", dut3.rr_ptr, 0);
    at_drive;
    rv3 = 3'b111;
    for (int i = 0; i < 6; i++) exp_q.push_back(32'(i % 3));
    for (int i = 0; i < 6; i++) begin
      at_sample;
      e = exp_q.pop_front();
      check("n3_rot_id", oid3, e);
      check("n3_ptr_range", (dut3.rr_ptr < 2'd3) ? 1 : 0, 1);
      at_drive;
    end
    rv3 = 3'b000;

    // Reset in the middle of a 4-beat packet from req3.
    rv = 4'b1000; rl = 4'b0000;
    at_sample;
    check("mid_id", oid, 3);
    at_drive;
    rstn = 1'b0;
    at_sample;
    check("mid_rst_valid", ov, 0);
    check("mid_rst_ready", rr, 0);
    check("mid_rst_lock", dut.lock, 0);
    at_drive;
    rstn = 1'b1; rv = 4'b1001;
    at_sample;
    check("restart_id", oid, 0);
    check("restart_ready", rr, 4'b0001);
    check("restart_valid", ov, 1);
    at_drive;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
